conv_layer_multi_p: RTL and testbench
=====================================

# conv_layer_multi_p

Parametrised multi-filter convolution layer: applies K filters of size D×F×F to one D×H×W image with stride S, using P parallel MAC lanes that process filter groups in turn. Fixed-point arithmetic with saturation, optional ReLU, and a start/busy/done handshake. It replaces the fixed two-lane, free-running multi-filter layer in the YOLOv5 conv datapath. It is self-contained and does not instantiate a single-filter submodule.

## Interface
- DATA_WIDTH, 16: signed two's-complement sample width.
- FRAC, 8: fractional bits of every operand and result.
- ACC_WIDTH, 40: accumulator width. Must be ≥ 2·DATA_WIDTH + clog2(D·F·F).
- D, 1: image and filter depth.
- H, 32 / W, 32: image height and width.
- F, 5: filter size.
- K, 6: number of filters.
- P, 2: parallel lanes, 1 ≤ P ≤ K. K need not be a multiple of P.
- S, 1: stride.
- Derived: OH=(H-F)/S+1, OW=(W-F)/S+1, T=D·F·F, G=ceil(K/P).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request, sampled only in IDLE.
- relu_en  in  1  clamp negative results to 0. Captured when start is accepted.
- image  in  D·H·W·DATA_WIDTH  flat bus declared [0:N-1]. Element (d,y,x) is at slot (d·H+y)·W+x, bits [slot·DW +: DW].
- filters  in  K·T·DATA_WIDTH  flat bus. Element (k,d,i,j) is at slot (k·D+d)·F·F+i·F+j.
- outputConv  out  K·OH·OW·DATA_WIDTH  registered. Element (k,r,c) is at slot (k·OH+r)·OW+c.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the whole layer is written.

## Operation
- States and transitions:
  - IDLE: on start=1 → MAC.
  - MAC: runs for T cycles → WRITE.
  - WRITE: 1 cycle → MAC for the next pixel/group, or → DONE after the last pixel of the last group.
  - DONE: 1 cycle → IDLE.
- Counters:
  - group g: 0..G-1.
  - row r: 0..OH-1.
  - col c: 0..OW-1.
  - tap t: 0..T-1, decomposed as d = t/(F·F), i = (t%(F·F))/F, j = t%F.
- Iteration order: tap innermost, then c, then r, then g.
- MAC cycle, lane p, filter k = g·P+p: acc_p += image(d, r·S+i, c·S+j) × filter(k,d,i,j).
  - Product is full 2·DW bits, sign-extended to ACC_WIDTH.
  - acc_p is cleared on entry to each pixel.
- WRITE cycle:
  - res = acc_p >>> FRAC (arithmetic shift, truncation toward −∞).
  - Saturate res to [−2^(DW-1), 2^(DW-1)−1].
  - If the captured relu_en=1 and res<0, res = 0.
  - Store res to slot (k,r,c) only if k < K. Lanes with k ≥ K (partial last group) compute nothing and write nothing.
- Output retention:
  - outputConv holds all written values after done, until overwritten by a later run.
  - A new start does not clear outputConv.
- start while busy (MAC/WRITE/DONE) is ignored. No queueing.
- image, filters and relu_en must be stable from start until done. This is a caller obligation; the block does not check it.

## Timing
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, all counters=0, accumulators=0.
  - outputConv=0, busy=0, done=0.
  - The partial run is abandoned.
- Let edge E0 be the edge that samples start=1 in IDLE:
  - busy=1 after E0.
  - done=1 after edge E0 + G·OH·OW·(T+1) + 1, for exactly one cycle.
  - busy=0 in the same cycle as done.
- The earliest next start is sampled on the edge that ends the DONE cycle, i.e. while the state has returned to IDLE.
- Each output pixel's value is visible on outputConv the cycle after its WRITE edge.

## Test plan
- Base config for tests 1–5: D=1, H=W=4, F=3, K=3, P=2, S=1, FRAC=8. Derived: OH=OW=2, T=9, G=2, latency 81.
- 1. Image all 0x0100 (1.0). Filter0 all 0x0100, filter1 all 0xFF00 (−1.0), filter2 all 0x0080 (0.5), relu_en=0. Pulse start → done exactly 81 edges later. Filter0 slots = 0x0900, filter1 slots = 0xF700, filter2 slots = 0x0480.
- 2. Same stimulus with relu_en=1 → filter1 slots = 0x0000, others unchanged.
- 3. Image all 0x7FFF, filter0 all 0x7FFF → filter0 slots saturate to 0x7FFF. With filter0 all 0x8000 → 0x8000.
- 4. Assert reset at cycle 40 of a run → outputConv=0, busy=0 immediately, no done pulse. Then pulse start → full correct result after 81 edges.
- 5. Pulse start again at cycles 10 and 80 of a run → ignored; exactly one done pulse. Pulse start in the cycle after done → accepted, second done 81 edges later.
- 6. Stride config: D=2, H=W=5, F=3, S=2, K=1, P=1 → OH=OW=2, latency 4·19+1 = 77. Image = ramp 0x0100·(index%4), filters all 0x0100 → each slot equals the software reference sum, shifted and saturated.

Source files
------------

// File: rtl/conv_layer_multi_p.sv
// Multi-filter convolution layer: K filters over one D x H x W image, P MAC lanes per filter group.
// Fixed-point multiply-accumulate with saturation, optional ReLU and a start/busy/done handshake.
module conv_layer_multi_p #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC       = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int K          = 6,
    parameter int P          = 2,
    parameter int S          = 1
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    start,
    input  logic                                                    relu_en,
    input  logic [0:D*H*W*DATA_WIDTH-1]                             image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]                           filters,
    output logic [K*((H-F)/S+1)*((W-F)/S+1)*DATA_WIDTH-1:0]         outputConv,
    output logic                                                    busy,
    output logic                                                    done
);
    localparam int OH  = (H - F) / S + 1;
    localparam int OW  = (W - F) / S + 1;
    localparam int G   = (K + P - 1) / P;
    localparam int DBW = (D > 1) ? $clog2(D) : 1;
    localparam int FBW = (F > 1) ? $clog2(F) : 1;
    localparam int RBW = (OH > 1) ? $clog2(OH) : 1;
    localparam int CBW = (OW > 1) ? $clog2(OW) : 1;
    localparam int GBW = (G > 1) ? $clog2(G) : 1;
    localparam int IMW = $clog2(D*H*W*DATA_WIDTH);
    localparam int FLW = $clog2(K*D*F*F*DATA_WIDTH);
    localparam int OUW = $clog2(K*OH*OW*DATA_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                        state_q, state_d;
    logic [DBW-1:0]                d_q;
    logic [FBW-1:0]                i_q, j_q;
    logic [RBW-1:0]                r_q;
    logic [CBW-1:0]                c_q;
    logic [GBW-1:0]                g_q;
    logic                          relu_q;
    logic signed [ACC_WIDTH-1:0]   acc_q [P];

    logic                          tap_last, pix_last;
    logic [IMW-1:0]                img_bit;
    logic signed [DATA_WIDTH-1:0]  pix, coef;
    logic signed [2*DATA_WIDTH-1:0] pix_ext, coef_ext;
    logic signed [2*DATA_WIDTH-1:0] prod [P];
    logic [P-1:0]                  lane_on;
    logic [FLW-1:0]                flt_bit [P];
    logic [OUW-1:0]                out_bit [P];
    logic signed [ACC_WIDTH-1:0]   shifted [P];
    logic [DATA_WIDTH-1:0]         res [P];

    assign tap_last = (d_q == DBW'(D-1)) && (i_q == FBW'(F-1)) && (j_q == FBW'(F-1));
    assign pix_last = (c_q == CBW'(OW-1)) && (r_q == RBW'(OH-1)) && (g_q == GBW'(G-1));

    always_comb begin
        img_bit  = IMW'(((int'(d_q)*H + int'(r_q)*S + int'(i_q))*W + int'(c_q)*S + int'(j_q)) * DATA_WIDTH);
        pix      = image[img_bit +: DATA_WIDTH];
        pix_ext  = {{DATA_WIDTH{pix[DATA_WIDTH-1]}}, pix};
        coef     = '0;
        coef_ext = '0;
        for (int p = 0; p < P; p++) begin
            lane_on[p] = (int'(g_q)*P + p) < K;
            flt_bit[p] = '0;
            out_bit[p] = '0;
            prod[p]    = '0;
            if (lane_on[p]) begin
                flt_bit[p] = FLW'(((((int'(g_q)*P + p)*D + int'(d_q))*F + int'(i_q))*F + int'(j_q)) * DATA_WIDTH);
                out_bit[p] = OUW'((((int'(g_q)*P + p)*OH + int'(r_q))*OW + int'(c_q)) * DATA_WIDTH);
                coef       = filters[flt_bit[p] +: DATA_WIDTH];
                coef_ext   = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef};
                prod[p]    = pix_ext * coef_ext;
            end
            // Arithmetic shift floors toward minus infinity before clamping to the sample range.
            shifted[p] = acc_q[p] >>> FRAC;
            if (shifted[p] > SAT_MAX)
                res[p] = SAT_MAX[DATA_WIDTH-1:0];
            else if (shifted[p] < SAT_MIN)
                res[p] = SAT_MIN[DATA_WIDTH-1:0];
            else
                res[p] = shifted[p][DATA_WIDTH-1:0];
            if (relu_q && shifted[p][ACC_WIDTH-1])
                res[p] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (tap_last) state_d = WRITE;
            WRITE:   state_d = pix_last ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            g_q        <= '0;
            relu_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            outputConv <= '0;
            for (int p = 0; p < P; p++) acc_q[p] <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    d_q    <= '0;
                    i_q    <= '0;
                    j_q    <= '0;
                    r_q    <= '0;
                    c_q    <= '0;
                    g_q    <= '0;
                    relu_q <= relu_en;
                    busy   <= 1'b1;
                    for (int p = 0; p < P; p++) acc_q[p] <= '0;
                end
                MAC: begin
                    for (int p = 0; p < P; p++)
                        acc_q[p] <= acc_q[p] + {{(ACC_WIDTH-2*DATA_WIDTH){prod[p][2*DATA_WIDTH-1]}}, prod[p]};
                    if (j_q == FBW'(F-1)) begin
                        j_q <= '0;
                        if (i_q == FBW'(F-1)) begin
                            i_q <= '0;
                            d_q <= (d_q == DBW'(D-1)) ? '0 : d_q + 1'b1;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                WRITE: begin
                    for (int p = 0; p < P; p++) begin
                        if (lane_on[p]) outputConv[out_bit[p] +: DATA_WIDTH] <= res[p];
                        acc_q[p] <= '0;
                    end
                    if (c_q == CBW'(OW-1)) begin
                        c_q <= '0;
                        if (r_q == RBW'(OH-1)) begin
                            r_q <= '0;
                            g_q <= (g_q == GBW'(G-1)) ? '0 : g_q + 1'b1;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_multi_p.sv
// Self-checking bench for conv_layer_multi_p: table vectors, random runs against a direct-formula
// reference, reset abort, start-while-busy handling and a strided two-channel configuration.
module tb_conv_layer_multi_p;
    localparam int DW = 16;
    localparam int AD = 1, AH = 4, AW = 4, AF = 3, AK = 3, AP = 2, AS = 1, AOH = 2, AOW = 2;
    localparam int LAT_A = 81;
    localparam int BD = 2, BH = 5, BW = 5, BF = 3, BK = 1, BP = 1, BS = 2, BOH = 2, BOW = 2;
    localparam int LAT_B = 77;
    localparam int IAW = $clog2(AD*AH*AW*DW);
    localparam int FAW = $clog2(AK*AD*AF*AF*DW);
    localparam int OAW = $clog2(AK*AOH*AOW*DW);
    localparam int IBW = $clog2(BD*BH*BW*DW);
    localparam int FBW = $clog2(BK*BD*BF*BF*DW);
    localparam int OBW = $clog2(BK*BOH*BOW*DW);

    logic clk = 1'b0;
    logic reset, start_a, start_b, relu_a, relu_b;
    logic [0:AD*AH*AW*DW-1]     image_a;
    logic [AK*AD*AF*AF*DW-1:0]  filters_a;
    logic [AK*AOH*AOW*DW-1:0]   out_a;
    logic                       busy_a, done_a;
    logic [0:BD*BH*BW*DW-1]     image_b;
    logic [BK*BD*BF*BF*DW-1:0]  filters_b;
    logic [BK*BOH*BOW*DW-1:0]   out_b;
    logic                       busy_b, done_b;

    int checks = 0;
    int failures = 0;
    int imgA[$], fltA[$], imgB[$], fltB[$];

    typedef struct {
        logic [15:0] pix, f0, f1, f2;
        logic        relu;
        logic [15:0] e0, e1, e2;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .ACC_WIDTH(40), .D(AD), .H(AH), .W(AW),
                         .F(AF), .K(AK), .P(AP), .S(AS)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .relu_en(relu_a), .image(image_a),
        .filters(filters_a), .outputConv(out_a), .busy(busy_a), .done(done_a));

    conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .ACC_WIDTH(40), .D(BD), .H(BH), .W(BW),
                         .F(BF), .K(BK), .P(BP), .S(BS)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .relu_en(relu_b), .image(image_b),
        .filters(filters_b), .outputConv(out_b), .busy(busy_b), .done(done_b));

    // Straight sum over the filter window, then floor-shift, clamp and optional ReLU.
    function automatic int refPixel(input int dd, input int hh, input int ww, input int ff, input int ss,
                                    input bit relu, input int k, input int r, input int c,
                                    input int img[$], input int flt[$]);
        longint acc;
        longint v;
        acc = 0;
        for (int d = 0; d < dd; d++)
            for (int i = 0; i < ff; i++)
                for (int j = 0; j < ff; j++)
                    acc += longint'(img[(d*hh + r*ss + i)*ww + c*ss + j]) *
                           longint'(flt[((k*dd + d)*ff + i)*ff + j]);
        v = acc >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (relu && v < 0) v = 0;
        return int'(v);
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0d (0x%04h) expected=%0d (0x%04h)", name, got, got & 16'hFFFF, exp, exp & 16'hFFFF);
        end
    endtask

    task automatic loadA();
        for (int n = 0; n < AD*AH*AW; n++) image_a[IAW'(n*DW) +: DW] = DW'(imgA[n]);
        for (int n = 0; n < AK*AD*AF*AF; n++) filters_a[FAW'(n*DW) +: DW] = DW'(fltA[n]);
    endtask

    task automatic fillRandom(input int span);
        imgA.delete();
        fltA.delete();
        for (int n = 0; n < AD*AH*AW; n++) imgA.push_back(int'($urandom_range(0, 2*span-1)) - span);
        for (int n = 0; n < AK*AD*AF*AF; n++) fltA.push_back(int'($urandom_range(0, 2*span-1)) - span);
        relu_a = 1'($urandom_range(0, 1));
        loadA();
    endtask

    function automatic int slotA(input int slot);
        logic signed [DW-1:0] v;
        v = out_a[OAW'(slot*DW) +: DW];
        return int'(v);
    endfunction

    function automatic int slotB(input int slot);
        logic signed [DW-1:0] v;
        v = out_b[OBW'(slot*DW) +: DW];
        return int'(v);
    endfunction

    task automatic checkLayerA(input string tag);
        for (int k = 0; k < AK; k++)
            for (int r = 0; r < AOH; r++)
                for (int c = 0; c < AOW; c++)
                    checkOutput($sformatf("%s_k%0d_r%0d_c%0d", tag, k, r, c), slotA((k*AOH + r)*AOW + c),
                                refPixel(AD, AH, AW, AF, AS, relu_a, k, r, c, imgA, fltA));
    endtask

    // Called #1 after an edge; start is sampled on the next edge (E0). Extra start pulses are
    // raised after edge E0+ex so they land on edge E0+ex+1. Returns the edge count to done.
    task automatic applyStimulus(input int ex1, input int ex2, output int lat);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checkOutput("busy_after_start", int'(busy_a), 1);
        lat = 0;
        while (lat < 400) begin
            if (lat == ex1 || lat == ex2) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            lat++;
            if (lat == 40) checkOutput("busy_mid_run", int'(busy_a), 1);
            if (done_a) begin
                checkOutput("busy_low_at_done", int'(busy_a), 0);
                break;
            end
        end
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done_a) n++;
        end
    endtask

    initial begin
        int lat, nd, exp;
        vecs[0] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0080, 1'b0, 16'h0900, 16'hF700, 16'h0480};
        vecs[1] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0080, 1'b1, 16'h0900, 16'h0000, 16'h0480};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 16'h047F};
        vecs[3] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 16'h8000, 16'hFB80, 16'h0000};
        vecs[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0100, 1'b1, 16'h0000, 16'h0000, 16'h7FFF};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; relu_a = 1'b0; relu_b = 1'b0;
        image_a = '0; filters_a = '0; image_b = '0; filters_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_zero", int'(out_a != '0), 0);
        checkOutput("reset_busy", int'(busy_a), 0);
        checkOutput("reset_done", int'(done_a), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Uniform table vectors with hand-derived results per filter.
        for (int v = 0; v < 5; v++) begin
            imgA.delete();
            fltA.delete();
            for (int n = 0; n < AH*AW; n++) imgA.push_back(int'($signed(vecs[v].pix)));
            for (int n = 0; n < 9; n++) fltA.push_back(int'($signed(vecs[v].f0)));
            for (int n = 0; n < 9; n++) fltA.push_back(int'($signed(vecs[v].f1)));
            for (int n = 0; n < 9; n++) fltA.push_back(int'($signed(vecs[v].f2)));
            relu_a = vecs[v].relu;
            loadA();
            applyStimulus(-1, -1, lat);
            checkOutput($sformatf("vec%0d_latency", v), lat, LAT_A);
            for (int s = 0; s < AK*AOH*AOW; s++) begin
                exp = (s < 4) ? int'($signed(vecs[v].e0)) : (s < 8) ? int'($signed(vecs[v].e1)) : int'($signed(vecs[v].e2));
                checkOutput($sformatf("vec%0d_slot%0d", v, s), slotA(s), exp);
            end
        end

        // Random runs against the reference model.
        for (int n = 0; n < 4; n++) begin
            fillRandom((n % 2 == 0) ? 32768 : 512);
            applyStimulus(-1, -1, lat);
            checkOutput($sformatf("rand%0d_latency", n), lat, LAT_A);
            checkLayerA($sformatf("rand%0d", n));
        end

        // Reset partway through a run: everything clears and no done follows.
        fillRandom(32768);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_out_zero", int'(out_a != '0), 0);
        checkOutput("abort_busy", int'(busy_a), 0);
        checkOutput("abort_done", int'(done_a), 0);
        #1;
        reset = 1'b0;
        countDone(120, nd);
        checkOutput("abort_no_done", nd, 0);
        checkOutput("abort_idle_busy", int'(busy_a), 0);
        imgA.delete();
        fltA.delete();
        for (int n = 0; n < AH*AW; n++) imgA.push_back(256);
        for (int n = 0; n < 27; n++) fltA.push_back((n < 9) ? 256 : (n < 18) ? -256 : 128);
        relu_a = 1'b0;
        loadA();
        applyStimulus(-1, -1, lat);
        checkOutput("after_abort_latency", lat, LAT_A);
        checkLayerA("after_abort");

        // Starts during MAC and DONE are ignored; a start in the done cycle is accepted.
        fillRandom(4096);
        applyStimulus(10, 80, lat);
        checkOutput("busy_start_latency", lat, LAT_A);
        checkLayerA("busy_start");
        fillRandom(4096);
        applyStimulus(-1, -1, lat);
        checkOutput("back_to_back_latency", lat, LAT_A);
        checkLayerA("back_to_back");
        countDone(100, nd);
        checkOutput("no_extra_done", nd, 0);

        // Strided, two-channel configuration on the second instance.
        imgB.delete();
        fltB.delete();
        for (int n = 0; n < BD*BH*BW; n++) imgB.push_back(256 * (n % 4));
        for (int n = 0; n < BK*BD*BF*BF; n++) fltB.push_back(256);
        for (int n = 0; n < BD*BH*BW; n++) image_b[IBW'(n*DW) +: DW] = DW'(imgB[n]);
        for (int n = 0; n < BK*BD*BF*BF; n++) filters_b[FBW'(n*DW) +: DW] = DW'(fltB[n]);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (done_b) break;
        end
        checkOutput("stride_latency", lat, LAT_B);
        checkOutput("stride_slot0_hand", slotB(0), 16'h1D00);
        for (int r = 0; r < BOH; r++)
            for (int c = 0; c < BOW; c++)
                checkOutput($sformatf("stride_r%0d_c%0d", r, c), slotB(r*BOW + c),
                            refPixel(BD, BH, BW, BF, BS, 1'b0, 0, r, c, imgB, fltB));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
